// File: rtl/alu_arbiter_if.sv
// Bus bundle between the two requesters, the shared ALU and the response consumer.
// The slave modport is the arbiter's view; the master modport is the surrounding logic's view.
interface alu_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int SELW  = 3
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [SELW-1:0]  req0_sel;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [SELW-1:0]  req1_sel;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [SELW-1:0]  alu_sel;
  logic [WIDTH-1:0] alu_out;
  logic             alu_carry;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_out;
  logic             rsp_carry;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel,
    input  req1_valid, req1_a, req1_b, req1_sel,
    input  alu_out, alu_carry, rsp_ready,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_sel,
    output rsp_valid, rsp_id, rsp_out, rsp_carry
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_sel,
    output req1_valid, req1_a, req1_b, req1_sel,
    output alu_out, alu_carry, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_sel,
    input  rsp_valid, rsp_id, rsp_out, rsp_carry
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between two requesters.
// Optional ALU_ARB_STATS_EN adds saturating 8-bit per-requester grant counters.
//
// state | meaning
// IDLE  | waiting for a request; ready driven to the grant winner
// EXEC  | latched operation on the ALU; result captured at the edge
// RESP  | response held until the consumer accepts it
module alu_arbiter #(
  parameter int WIDTH = 4,
  parameter int SELW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  alu_arbiter_if.slave     bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [7:0]       grant_cnt0,
  output logic [7:0]       grant_cnt1
`endif
);

  localparam logic [SELW-1:0] NOP = '1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [SELW-1:0]  sel_q;
  logic             id_q;
  logic             ptr;
  logic             grant0;
  logic             grant1;

  // Pointer names the favoured requester when both are valid.
  always_comb begin
    grant0 = (state == IDLE) && bus.req0_valid && (!bus.req1_valid || !ptr);
    grant1 = (state == IDLE) && bus.req1_valid && (!bus.req0_valid ||  ptr);
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  // sel_q carries the opcode only during EXEC and reverts to NOP afterwards.
  assign bus.alu_sel    = sel_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      sel_q         <= NOP;
      id_q          <= 1'b0;
      ptr           <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_out   <= '0;
      bus.rsp_carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0) begin
            a_q   <= bus.req0_a;
            b_q   <= bus.req0_b;
            sel_q <= bus.req0_sel;
            id_q  <= 1'b0;
            state <= EXEC;
          end else if (grant1) begin
            a_q   <= bus.req1_a;
            b_q   <= bus.req1_b;
            sel_q <= bus.req1_sel;
            id_q  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          bus.rsp_out   <= bus.alu_out;
          bus.rsp_carry <= bus.alu_carry;
          bus.rsp_id    <= id_q;
          bus.rsp_valid <= 1'b1;
          sel_q         <= NOP;
          state         <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            ptr           <= ~bus.rsp_id;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0 <= 8'd0;
      grant_cnt1 <= 8'd0;
    end else begin
      if (grant0 && grant_cnt0 != 8'hff) grant_cnt0 <= grant_cnt0 + 8'd1;
      if (grant1 && grant_cnt1 != 8'hff) grant_cnt1 <= grant_cnt1 + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural 4-bit ALU on the shared port.
// ALU opcodes here: 000 add, 001 sub, 010 and, 011 or, 100 xor, 111 nop (passes a).
module tb_alu_arbiter;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [4:0] alu_r;
`ifdef ALU_ARB_STATS_EN
  logic [7:0] grant_cnt0;
  logic [7:0] grant_cnt1;
  int         ngrant;
  int         budget;
`endif

  alu_arbiter_if #(.WIDTH(4), .SELW(3)) bus ();

  alu_arbiter #(.WIDTH(4), .SELW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    alu_r = {1'b0, bus.alu_a};
    case (bus.alu_sel)
      3'b000:  alu_r = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      3'b001:  alu_r = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      3'b010:  alu_r = {1'b0, bus.alu_a & bus.alu_b};
      3'b011:  alu_r = {1'b0, bus.alu_a | bus.alu_b};
      3'b100:  alu_r = {1'b0, bus.alu_a ^ bus.alu_b};
      default: alu_r = {1'b0, bus.alu_a};
    endcase
  end
  assign bus.alu_out   = alu_r[3:0];
  assign bus.alu_carry = alu_r[4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_sel = 3'b111;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_sel = 3'b111;
    bus.rsp_ready  = 1'b1;
    step();
    step();
    rst = 1'b0;

    chk("rst_rsp_valid", {7'd0, bus.rsp_valid}, 8'd0);
    chk("rst_rsp_id",    {7'd0, bus.rsp_id},    8'd0);
    chk("rst_rsp_out",   {4'd0, bus.rsp_out},   8'd0);
    chk("rst_rsp_carry", {7'd0, bus.rsp_carry}, 8'd0);
    chk("rst_alu_sel",   {5'd0, bus.alu_sel},   8'd7);
    chk("rst_alu_a",     {4'd0, bus.alu_a},     8'd0);

    // single op: 3 + 1 from requester 0
    bus.req0_valid = 1'b1; bus.req0_a = 4'b0011; bus.req0_b = 4'b0001; bus.req0_sel = 3'b000;
    #1;
    chk("op1_ready0", {7'd0, bus.req0_ready}, 8'd1);
    chk("op1_ready1", {7'd0, bus.req1_ready}, 8'd0);
    step();
    bus.req0_valid = 1'b0;
    chk("op1_exec_sel",   {5'd0, bus.alu_sel}, 8'd0);
    chk("op1_exec_a",     {4'd0, bus.alu_a},   8'd3);
    chk("op1_exec_valid", {7'd0, bus.rsp_valid}, 8'd0);
    step();
    chk("op1_valid", {7'd0, bus.rsp_valid}, 8'd1);
    chk("op1_out",   {4'd0, bus.rsp_out},   8'h4);
    chk("op1_carry", {7'd0, bus.rsp_carry}, 8'd0);
    chk("op1_id",    {7'd0, bus.rsp_id},    8'd0);
    chk("op1_resp_sel", {5'd0, bus.alu_sel}, 8'd7);
    step();
    chk("op1_done", {7'd0, bus.rsp_valid}, 8'd0);

    // carry: F + 1 from requester 1
    bus.req1_valid = 1'b1; bus.req1_a = 4'b1111; bus.req1_b = 4'b0001; bus.req1_sel = 3'b000;
    #1;
    chk("cy_ready1", {7'd0, bus.req1_ready}, 8'd1);
    step();
    bus.req1_valid = 1'b0;
    step();
    chk("cy_out",   {4'd0, bus.rsp_out},   8'h0);
    chk("cy_carry", {7'd0, bus.rsp_carry}, 8'd1);
    chk("cy_id",    {7'd0, bus.rsp_id},    8'd1);
    step();

    // contention: pointer is 0, so req0 (AND) goes first
    bus.req0_valid = 1'b1; bus.req0_a = 4'b1100; bus.req0_b = 4'b1010; bus.req0_sel = 3'b010;
    bus.req1_valid = 1'b1; bus.req1_a = 4'b1100; bus.req1_b = 4'b1010; bus.req1_sel = 3'b011;
    #1;
    chk("ct_ready0", {7'd0, bus.req0_ready}, 8'd1);
    chk("ct_ready1", {7'd0, bus.req1_ready}, 8'd0);
    step();
    bus.req0_valid = 1'b0;
    chk("ct_exec_ready1", {7'd0, bus.req1_ready}, 8'd0);
    step();
    chk("ct_out0",  {4'd0, bus.rsp_out}, 8'h8);
    chk("ct_id0",   {7'd0, bus.rsp_id},  8'd0);
    chk("ct_resp_ready1", {7'd0, bus.req1_ready}, 8'd0);
    step();
    // second round: req0 returns, but req1 is now favoured
    bus.req0_valid = 1'b1;
    #1;
    chk("ct2_ready1", {7'd0, bus.req1_ready}, 8'd1);
    chk("ct2_ready0", {7'd0, bus.req0_ready}, 8'd0);
    step();
    bus.req1_valid = 1'b0;
    step();
    chk("ct2_out1", {4'd0, bus.rsp_out}, 8'hE);
    chk("ct2_id1",  {7'd0, bus.rsp_id},  8'd1);
    step();
    chk("ct3_ready0", {7'd0, bus.req0_ready}, 8'd1);
    step();
    bus.req0_valid = 1'b0;
    step();
    chk("ct3_out0", {4'd0, bus.rsp_out}, 8'h8);
    chk("ct3_id0",  {7'd0, bus.rsp_id},  8'd0);
    step();

    // backpressure: req0 XOR held five cycles while req1 waits
    bus.rsp_ready  = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 4'b1100; bus.req0_b = 4'b1010; bus.req0_sel = 3'b100;
    step();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 4'b0011; bus.req1_b = 4'b0100; bus.req1_sel = 3'b011;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid",  {7'd0, bus.rsp_valid},  8'd1);
      chk("bp_out",    {4'd0, bus.rsp_out},    8'h6);
      chk("bp_id",     {7'd0, bus.rsp_id},     8'd0);
      chk("bp_ready1", {7'd0, bus.req1_ready}, 8'd0);
      step();
    end
    bus.rsp_ready = 1'b1;
    step();
    chk("bp_done",   {7'd0, bus.rsp_valid},  8'd0);
    chk("bp_ready1_after", {7'd0, bus.req1_ready}, 8'd1);
    step();
    bus.req1_valid = 1'b0;
    step();
    chk("bp_out1", {4'd0, bus.rsp_out}, 8'h7);
    chk("bp_id1",  {7'd0, bus.rsp_id},  8'd1);
    step();

    // reset in EXEC drops the operation
    bus.req0_valid = 1'b1; bus.req0_a = 4'b0001; bus.req0_b = 4'b0001; bus.req0_sel = 3'b000;
    step();
    bus.req0_valid = 1'b0;
    chk("rm_exec_sel", {5'd0, bus.alu_sel}, 8'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rm_valid", {7'd0, bus.rsp_valid}, 8'd0);
    chk("rm_sel",   {5'd0, bus.alu_sel},   8'd7);
    step();
    step();
    chk("rm_no_rsp", {7'd0, bus.rsp_valid}, 8'd0);
    bus.req1_valid = 1'b1; bus.req1_a = 4'b0100; bus.req1_b = 4'b0001; bus.req1_sel = 3'b001;
    #1;
    chk("rm_ready1", {7'd0, bus.req1_ready}, 8'd1);
    step();
    bus.req1_valid = 1'b0;
    step();
    chk("rm_sub_out",   {4'd0, bus.rsp_out},   8'h3);
    chk("rm_sub_carry", {7'd0, bus.rsp_carry}, 8'd0);
    chk("rm_sub_id",    {7'd0, bus.rsp_id},    8'd1);
    step();

    // NOP opcode is sequenced and the ALU result passes through
    bus.req0_valid = 1'b1; bus.req0_a = 4'b0101; bus.req0_b = 4'b1001; bus.req0_sel = 3'b111;
    step();
    bus.req0_valid = 1'b0;
    step();
    chk("nop_valid", {7'd0, bus.rsp_valid}, 8'd1);
    chk("nop_out",   {4'd0, bus.rsp_out},   8'h5);
    step();

`ifdef ALU_ARB_STATS_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("st_rst_cnt0", grant_cnt0, 8'd0);
    chk("st_rst_cnt1", grant_cnt1, 8'd0);
    bus.req0_valid = 1'b1; bus.req0_a = 4'b0001; bus.req0_b = 4'b0010; bus.req0_sel = 3'b000;
    ngrant = 0;
    budget = 0;
    while (ngrant < 300 && budget < 2000) begin
      if (bus.req0_ready) ngrant++;
      step();
      budget++;
    end
    bus.req0_valid = 1'b0;
    chk("st_grants_seen", (ngrant == 300) ? 8'd1 : 8'd0, 8'd1);
    chk("st_cnt0", grant_cnt0, 8'd255);
    chk("st_cnt1", grant_cnt1, 8'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
